// File: rtl/tl_host_adapter_if.sv
// Host request port (req/gnt/rvalid) plus TileLink-UL Channels A and D.
// master: the adapter's view; slave: the host CPU and crossbar it connects to.
interface tl_host_adapter_if #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
   parameter int unsigned SIZE_WIDTH   = 3,
   parameter int unsigned OPCODE_WIDTH = 3,
   parameter int unsigned PARAM_WIDTH  = 3
);
   logic                    req;
   logic                    we;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [MASK_WIDTH-1:0]   be;
   logic                    gnt;
   logic                    rvalid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    err;

   logic                    a_valid;
   logic                    a_ready;
   logic [OPCODE_WIDTH-1:0] a_opcode;
   logic [PARAM_WIDTH-1:0]  a_param;
   logic [SIZE_WIDTH-1:0]   a_size;
   logic                    a_source;
   logic [ADDR_WIDTH-1:0]   a_address;
   logic [MASK_WIDTH-1:0]   a_mask;
   logic [DATA_WIDTH-1:0]   a_data;

   logic                    d_valid;
   logic                    d_ready;
   logic [OPCODE_WIDTH-1:0] d_opcode;
   logic [PARAM_WIDTH-1:0]  d_param;
   logic [SIZE_WIDTH-1:0]   d_size;
   logic                    d_source;
   logic                    d_sink;
   logic [DATA_WIDTH-1:0]   d_data;
   logic                    d_error;

   modport master (
      input  req, we, addr, wdata, be,
      output gnt, rvalid, rdata, err,
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
      input  a_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
      output d_ready
   );

   modport slave (
      output req, we, addr, wdata, be,
      input  gnt, rvalid, rdata, err,
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
      output a_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
      input  d_ready
   );
endinterface

// File: rtl/tl_host_adapter.sv
// Single-outstanding bridge from a req/gnt/rvalid host port onto TileLink-UL
// Channels A/D of xbar_main, with a response timeout for hung slaves.
module tl_host_adapter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
   parameter int unsigned SIZE_WIDTH   = 3,
   parameter int unsigned OPCODE_WIDTH = 3,
   parameter int unsigned PARAM_WIDTH  = 3,
   parameter int unsigned TIMEOUT      = 1024
) (
   input  logic               clk,
   input  logic               reset,
   tl_host_adapter_if.master  bus
);

   localparam int unsigned A_SIZE     = $clog2(MASK_WIDTH);
   localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
   localparam int unsigned TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   localparam logic [OPCODE_WIDTH-1:0] OP_GET          = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL     = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PARTIAL  = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_ACCESS_ACK   = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_ACCESS_ACK_D = OPCODE_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      A_SEND = 2'd1,
      D_WAIT = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    gnt, a_valid, d_ready;
   logic                    capture, resp, expire;

   logic                    is_write_q;
   logic [OPCODE_WIDTH-1:0] a_opcode_q;
   logic [SIZE_WIDTH-1:0]   a_size_q;
   logic [ADDR_WIDTH-1:0]   a_address_q;
   logic [MASK_WIDTH-1:0]   a_mask_q;
   logic [DATA_WIDTH-1:0]   a_data_q;
   logic                    rvalid_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    err_q;
   logic [TIMER_W-1:0]      timer_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      gnt     = 1'b0;
      a_valid = 1'b0;
      d_ready = 1'b1;
      capture = 1'b0;
      resp    = 1'b0;
      expire  = 1'b0;
      unique case (state_q)
         IDLE: begin
            gnt = bus.req;
            if (bus.req) begin
               capture = 1'b1;
               state_d = A_SEND;
            end
         end
         A_SEND: begin
            a_valid = 1'b1;
            d_ready = 1'b0;
            if (bus.a_ready) state_d = D_WAIT;
         end
         D_WAIT: begin
            // A beat arriving on the expiry cycle still wins over the timeout.
            if (bus.d_valid) begin
               resp    = 1'b1;
               state_d = IDLE;
            end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
               expire  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         is_write_q  <= 1'b0;
         a_opcode_q  <= '0;
         a_size_q    <= '0;
         a_address_q <= '0;
         a_mask_q    <= '0;
         a_data_q    <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         timer_q     <= '0;
      end else begin
         rvalid_q <= resp | expire;
         rdata_q  <= '0;
         err_q    <= 1'b0;

         if (capture) begin
            is_write_q  <= bus.we;
            a_size_q    <= SIZE_WIDTH'(A_SIZE);
            a_address_q <= bus.addr;
            if (bus.we) begin
               a_opcode_q <= (&bus.be) ? OP_PUT_FULL : OP_PUT_PARTIAL;
               a_mask_q   <= bus.be;
               a_data_q   <= bus.wdata;
            end else begin
               a_opcode_q <= OP_GET;
               a_mask_q   <= '1;
               a_data_q   <= '0;
            end
         end

         if (state_q == A_SEND && bus.a_ready)
            timer_q <= '0;
         else if (state_q == D_WAIT && !bus.d_valid)
            timer_q <= timer_q + 1'b1;

         if (resp) begin
            rdata_q <= is_write_q ? '0 : bus.d_data;
            err_q   <= bus.d_error |
                       (bus.d_opcode != (is_write_q ? OP_ACCESS_ACK : OP_ACCESS_ACK_D));
         end else if (expire) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.gnt       = gnt;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.err       = err_q;
   assign bus.a_valid   = a_valid;
   assign bus.a_opcode  = a_opcode_q;
   assign bus.a_param   = PARAM_WIDTH'(0);
   assign bus.a_size    = a_size_q;
   assign bus.a_source  = 1'b0;
   assign bus.a_address = a_address_q;
   assign bus.a_mask    = a_mask_q;
   assign bus.a_data    = a_data_q;
   assign bus.d_ready   = d_ready;

   // Single source/sink ID and fixed size: these D fields carry nothing to check.
   logic unused_d_fields;
   assign unused_d_fields = ^{bus.d_param, bus.d_size, bus.d_source, bus.d_sink};

endmodule

// File: tb/tb_tl_host_adapter.sv
// Directed bench for tl_host_adapter: a transaction-level model predicts A beats,
// completions and handshake timing; a negedge monitor compares every cycle.
module tb_tl_host_adapter;

   localparam int TIMEOUT = 8;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          a_wait;
      int          d_delay;
      logic [2:0]  d_op;
      logic [31:0] d_data;
      bit          d_err;
      bit          b2b;
   } txn_t;

   typedef struct {
      logic [2:0]  opcode;
      logic [3:0]  mask;
      logic [31:0] data;
      logic [31:0] address;
   } a_exp_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } comp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tl_host_adapter_if bus ();

   tl_host_adapter #(.TIMEOUT(TIMEOUT)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   function automatic a_exp_t exp_a_of(input txn_t t);
      a_exp_t e;
      e.address = t.addr;
      if (t.we) begin
         e.opcode = (t.be == 4'hF) ? 3'd0 : 3'd1;
         e.mask   = t.be;
         e.data   = t.wdata;
      end else begin
         e.opcode = 3'd4;
         e.mask   = 4'hF;
         e.data   = 32'h0;
      end
      return e;
   endfunction

   function automatic comp_t exp_comp_of(input txn_t t);
      comp_t c;
      if (t.d_delay < 0 || t.d_delay >= TIMEOUT) begin
         c.rdata = 32'h0;
         c.err   = 1'b1;
      end else begin
         c.rdata = t.we ? 32'h0 : t.d_data;
         c.err   = t.d_err | (t.d_op != (t.we ? 3'd0 : 3'd1));
      end
      return c;
   endfunction

   a_exp_t exp_a_q[$];
   comp_t  exp_c_q[$];
   txn_t   cfg_q[$];

   int          outstanding, a_pending, d_phase, d_wait_n, due, a_cycles;
   int          n_rvalid = 0;
   int          last_a_cycles;
   logic [2:0]  last_opcode;
   logic [3:0]  last_mask;
   logic [2:0]  last_size;
   logic [31:0] last_a_data;
   logic [31:0] last_rdata;
   logic        last_err;

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!reset) begin
         exp_a_q.delete();
         exp_c_q.delete();
         outstanding = 0; a_pending = 0; d_phase = 0; d_wait_n = 0; due = 0; a_cycles = 0;
      end else begin
         check("rvalid_timing", bus.rvalid, due);
         if (bus.rvalid) begin
            n_rvalid++;
            if (exp_c_q.size() == 0) check("rvalid_unexpected", bus.rvalid, 1'b0);
            else begin
               comp_t c;
               c = exp_c_q.pop_front();
               check("rdata", bus.rdata, c.rdata);
               check("err", bus.err, c.err);
               last_rdata = bus.rdata;
               last_err   = bus.err;
            end
            outstanding = 0;
         end
         due = 0;

         check("gnt", bus.gnt, bus.req && (outstanding == 0));
         check("a_valid", bus.a_valid, a_pending != 0);
         check("d_ready", bus.d_ready, a_pending == 0);

         if (bus.a_valid) begin
            if (exp_a_q.size() == 0) check("a_unexpected", bus.a_valid, 1'b0);
            else begin
               check("a_opcode",  bus.a_opcode,  exp_a_q[0].opcode);
               check("a_mask",    bus.a_mask,    exp_a_q[0].mask);
               check("a_data",    bus.a_data,    exp_a_q[0].data);
               check("a_address", bus.a_address, exp_a_q[0].address);
               check("a_size",    bus.a_size,    3'd2);
               check("a_param",   bus.a_param,   3'd0);
               check("a_source",  bus.a_source,  1'b0);
            end
            a_cycles++;
            if (bus.a_ready) begin
               if (exp_a_q.size() != 0) void'(exp_a_q.pop_front());
               last_opcode   = bus.a_opcode;
               last_mask     = bus.a_mask;
               last_size     = bus.a_size;
               last_a_data   = bus.a_data;
               last_a_cycles = a_cycles;
               a_cycles  = 0;
               a_pending = 0;
               d_phase   = 1;
               d_wait_n  = 0;
            end
         end else if (d_phase != 0) begin
            if (bus.d_valid || d_wait_n == TIMEOUT - 1) begin
               due     = 1;
               d_phase = 0;
            end else begin
               d_wait_n++;
            end
         end

         if (bus.gnt) begin
            outstanding = 1;
            a_pending   = 1;
         end
      end
   end

   // ---------------- slave (xbar) emulation ----------------
   txn_t cur_a, cur_d;
   int   a_active, a_cnt, d_active, d_cnt;

   initial begin
      bus.a_ready = 1'b0; bus.d_valid = 1'b0; bus.d_opcode = '0; bus.d_param = '0;
      bus.d_size = 3'd2; bus.d_source = 1'b0; bus.d_sink = 1'b0; bus.d_data = '0; bus.d_error = 1'b0;
      a_active = 0; a_cnt = 0; d_active = 0; d_cnt = 0;
      forever begin
         @(posedge clk); #1;
         bus.d_valid = 1'b0;
         if (!reset) begin
            bus.a_ready = 1'b0;
            cfg_q.delete();
            a_active = 0; d_active = 0;
         end else begin
            if (bus.a_ready) begin
               bus.a_ready = 1'b0;
               a_active = 0;
               d_active = 1;
               d_cnt    = 0;
               cur_d    = cur_a;
            end
            if (d_active != 0) begin
               if (cur_d.d_delay >= 0 && d_cnt == cur_d.d_delay) begin
                  bus.d_valid  = 1'b1;
                  bus.d_opcode = cur_d.d_op;
                  bus.d_data   = cur_d.d_data;
                  bus.d_error  = cur_d.d_err;
                  d_active     = 0;
               end else if (d_cnt > 100) d_active = 0;
               else d_cnt++;
            end
            if (bus.a_valid) begin
               if (a_active == 0) begin
                  if (cfg_q.size() != 0) cur_a = cfg_q.pop_front();
                  a_active = 1;
                  a_cnt    = 0;
               end
               if (a_cnt >= cur_a.a_wait) bus.a_ready = 1'b1;
               else a_cnt++;
            end
         end
      end
   end

   // ---------------- host driver ----------------
   txn_t tx[11];
   int   rv_base, run_len, chained;

   function automatic txn_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int a_wait, input int d_delay,
                               input logic [2:0] d_op, input logic [31:0] d_data,
                               input bit d_err, input bit b2b);
      txn_t t;
      t.we = we; t.addr = addr; t.wdata = wdata; t.be = be; t.a_wait = a_wait;
      t.d_delay = d_delay; t.d_op = d_op; t.d_data = d_data; t.d_err = d_err; t.b2b = b2b;
      return t;
   endfunction

   task automatic present(input txn_t t);
      bus.req = 1'b1; bus.we = t.we; bus.addr = t.addr; bus.wdata = t.wdata; bus.be = t.be;
      exp_a_q.push_back(exp_a_of(t));
      exp_c_q.push_back(exp_comp_of(t));
      cfg_q.push_back(t);
   endtask

   task automatic wait_gnt();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.gnt && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.gnt) check("gnt_wait", bus.gnt, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic pins(input int i);
      case (i)
         0: begin
            check("t1_opcode", last_opcode, 3'd4);
            check("t1_mask",   last_mask,   4'hF);
            check("t1_size",   last_size,   3'd2);
            check("t1_rdata",  last_rdata,  32'hDEADBEEF);
            check("t1_err",    last_err,    1'b0);
         end
         1: begin
            check("t2_opcode",   last_opcode,   3'd1);
            check("t2_mask",     last_mask,     4'h3);
            check("t2_data",     last_a_data,   32'h1234);
            check("t2_a_cycles", last_a_cycles, 4);
            check("t2_rdata",    last_rdata,    32'h0);
            check("t2_err",      last_err,      1'b0);
         end
         2: begin
            check("t3_derr_err",   last_err,   1'b1);
            check("t3_derr_rdata", last_rdata, 32'h55);
         end
         3: begin
            check("t3_put_full",    last_opcode, 3'd0);
            check("t3_mismatch_err", last_err,   1'b1);
         end
         4: begin
            check("t4_timeout_err",   last_err,   1'b1);
            check("t4_timeout_rdata", last_rdata, 32'h0);
         end
         5: begin
            check("t4_edge_err",   last_err,   1'b0);
            check("t4_edge_rdata", last_rdata, 32'h77);
         end
         6: check("t4_expire_err", last_err, 1'b1);
         9: begin
            check("t5_last_opcode", last_opcode, 3'd1);
            check("t5_last_mask",   last_mask,   4'hC);
         end
         10: begin
            check("t6_after_rst_rdata", last_rdata, 32'hA5A50001);
            check("t6_after_rst_err",   last_err,   1'b0);
         end
         default: ;
      endcase
   endtask

   task automatic run_one(input int i);
      int n;
      if (chained == 0) begin
         rv_base = n_rvalid;
         run_len = 0;
      end
      run_len++;
      present(tx[i]);
      wait_gnt();
      if (tx[i].b2b) begin
         chained = 1;
         return;
      end
      chained = 0;
      bus.req = 1'b0;
      n = 0;
      while (outstanding != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (outstanding != 0) check("done_wait", outstanding, 0);
      repeat (8) begin
         @(posedge clk); #1;
      end
      check("rvalid_count", n_rvalid - rv_base, run_len);
      pins(i);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
      $fatal(1, "watchdog");
   end

   initial begin
      tx[0]  = mk(0, 32'h1000, 32'h0,        4'h0, 0, 0,  3'd1, 32'hDEADBEEF, 0, 0);
      tx[1]  = mk(1, 32'h2004, 32'h1234,     4'h3, 3, 1,  3'd0, 32'hFFFF0000, 0, 0);
      tx[2]  = mk(0, 32'h3000, 32'h0,        4'h0, 0, 2,  3'd1, 32'h55,       1, 0);
      tx[3]  = mk(1, 32'h3004, 32'hCAFEF00D, 4'hF, 1, 0,  3'd1, 32'h0,        0, 0);
      tx[4]  = mk(0, 32'h4000, 32'h0,        4'h0, 0, 12, 3'd1, 32'h99,       0, 0);
      tx[5]  = mk(0, 32'h4004, 32'h0,        4'h0, 0, 7,  3'd1, 32'h77,       0, 0);
      tx[6]  = mk(0, 32'h4008, 32'h0,        4'h0, 0, 8,  3'd1, 32'h88,       0, 0);
      tx[7]  = mk(1, 32'h5000, 32'h11111111, 4'hF, 0, 0,  3'd0, 32'h0,        0, 1);
      tx[8]  = mk(0, 32'h5004, 32'h0,        4'h0, 2, 1,  3'd1, 32'h22,       0, 1);
      tx[9]  = mk(1, 32'h5008, 32'h33333333, 4'hC, 0, 3,  3'd0, 32'h0,        0, 0);
      tx[10] = mk(0, 32'h6004, 32'h0,        4'h0, 0, 0,  3'd1, 32'hA5A50001, 0, 0);

      reset = 1'b0;
      bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
      chained = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_a_valid", bus.a_valid,  1'b0);
      check("rst_d_ready", bus.d_ready,  1'b1);
      check("rst_rvalid",  bus.rvalid,   1'b0);
      check("rst_gnt",     bus.gnt,      1'b0);
      check("rst_rdata",   bus.rdata,    32'h0);
      check("rst_err",     bus.err,      1'b0);
      check("rst_opcode",  bus.a_opcode, 3'd0);
      check("rst_size",    bus.a_size,   3'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end

      for (int i = 0; i < 10; i++) run_one(i);

      // Reset while a request sits in A_SEND behind a stalled a_ready.
      present(mk(0, 32'h6000, 32'h0, 4'h0, 10, 0, 3'd1, 32'hBAD, 0, 0));
      wait_gnt();
      bus.req = 1'b0;
      @(posedge clk); #3;
      check("pre_rst_a_valid", bus.a_valid, 1'b1);
      rv_base = n_rvalid;
      reset = 1'b0;
      #1;
      check("arst_a_valid", bus.a_valid,   1'b0);
      check("arst_d_ready", bus.d_ready,   1'b1);
      check("arst_rvalid",  bus.rvalid,    1'b0);
      check("arst_address", bus.a_address, 32'h0);
      check("arst_mask",    bus.a_mask,    4'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
      end
      check("arst_no_rvalid", n_rvalid - rv_base, 0);

      run_one(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
